// File: rtl/fmap_write_sched.sv
// fmap_write_sched: sequences conv/ReLU activations into masked activation-SRAM writes.
// Define WRITE_MERGE_EN to stage all CH_NUM channels of a position into one merged write.
module fmap_write_sched #(
    parameter int CH_NUM       = 24,
    parameter int ACT_PER_ADDR = 4,
    parameter int BW_PER_ACT   = 16,
    parameter int ADDR_BW      = 10
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [5:0]                                cfg_rows,
    input  logic [5:0]                                cfg_cols,
    input  logic [ADDR_BW-1:0]                        cfg_base,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [BW_PER_ACT-1:0]                     in_data,
    output logic                                      sram_wen,
    output logic [ADDR_BW-1:0]                        sram_addr,
    output logic [CH_NUM*ACT_PER_ADDR-1:0]            sram_bytemask,
    output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_wdata,
    output logic                                      busy,
    output logic                                      done
);
    localparam int MW = CH_NUM * ACT_PER_ADDR;
    localparam int DW = MW * BW_PER_ACT;
    localparam int CW = $clog2(CH_NUM);
    localparam int PW = $clog2(ACT_PER_ADDR);
    localparam int KW = $clog2(MW);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [5:0]         rows_q, rows_d, cols_q, cols_d;
    logic [5:0]         row_q, row_d, col_q, col_d;
    logic [CW-1:0]      ch_q, ch_d;
    logic [PW-1:0]      pos_q, pos_d;
    logic [ADDR_BW-1:0] addr_q, addr_d, waddr_q, waddr_d;
    logic               wen_q, wen_d;
    logic [MW-1:0]      mask_q, mask_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic               acc, ch_wrap, pos_wrap, col_wrap, row_wrap, last;

`ifdef WRITE_MERGE_EN
    logic [BW_PER_ACT-1:0] stage_q [CH_NUM];
`else
    logic [KW-1:0] k;
    assign k = KW'(MW - 1) - KW'(ch_q * ACT_PER_ADDR + pos_q);
`endif

    assign in_ready      = state_q == RUN;
    assign busy          = state_q == RUN || state_q == DRAIN;
    assign done          = state_q == DONE;
    assign acc           = in_valid && in_ready;
    assign ch_wrap       = ch_q == CW'(CH_NUM - 1);
    assign pos_wrap      = pos_q == PW'(ACT_PER_ADDR - 1);
    assign col_wrap      = col_q == cols_q - 6'd1;
    assign row_wrap      = row_q == rows_q - 6'd1;
    assign last          = ch_wrap && pos_wrap && col_wrap && row_wrap;
    assign sram_wen      = wen_q;
    assign sram_addr     = waddr_q;
    assign sram_bytemask = mask_q;
    assign sram_wdata    = wdata_q;

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        cols_d  = cols_q;
        row_d   = row_q;
        col_d   = col_q;
        ch_d    = ch_q;
        pos_d   = pos_q;
        addr_d  = addr_q;
        waddr_d = waddr_q;
        wen_d   = 1'b1;
        mask_d  = '1;
        wdata_d = '0;
        case (state_q)
            IDLE: if (start) begin
                rows_d  = cfg_rows;
                cols_d  = cfg_cols;
                addr_d  = cfg_base;
                row_d   = '0;
                col_d   = '0;
                ch_d    = '0;
                pos_d   = '0;
                state_d = (cfg_rows != 6'd0 && cfg_cols != 6'd0) ? RUN : DONE;
            end
            RUN:     state_d = (acc && last) ? DRAIN : RUN;
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
        // the running address steps once per completed word, so row*cols+col needs no multiplier
        if (acc) begin
            ch_d = ch_wrap ? '0 : ch_q + CW'(1);
            if (ch_wrap) pos_d = pos_wrap ? '0 : pos_q + PW'(1);
            if (ch_wrap && pos_wrap) begin
                col_d  = col_wrap ? 6'd0 : col_q + 6'd1;
                addr_d = addr_q + ADDR_BW'(1);
                if (col_wrap) row_d = row_wrap ? 6'd0 : row_q + 6'd1;
            end
        end
`ifdef WRITE_MERGE_EN
        if (acc && ch_wrap) begin
            wen_d   = 1'b0;
            waddr_d = addr_q;
            for (int c = 0; c < CH_NUM; c++) begin
                mask_d  = mask_d & ~(MW'(1) << (MW - 1 - (c * ACT_PER_ADDR + int'(pos_q))));
                wdata_d = wdata_d | (DW'(c == CH_NUM - 1 ? in_data : stage_q[CW'(c)])
                          << ((MW - 1 - (c * ACT_PER_ADDR + int'(pos_q))) * BW_PER_ACT));
            end
        end
`else
        if (acc) begin
            wen_d   = 1'b0;
            waddr_d = addr_q;
            mask_d  = ~(MW'(1) << k);
            wdata_d = DW'(in_data) << (k * BW_PER_ACT);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rows_q  <= '0;
            cols_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            ch_q    <= '0;
            pos_q   <= '0;
            addr_q  <= '0;
            waddr_q <= '0;
            wen_q   <= 1'b1;
            mask_q  <= '1;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ch_q    <= ch_d;
            pos_q   <= pos_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            wen_q   <= wen_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef WRITE_MERGE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CH_NUM; c++) stage_q[CW'(c)] <= '0;
        end else if (acc) begin
            stage_q[ch_q] <= in_data;
        end
    end
`endif
endmodule

// File: doc/fmap_write_sched.md
# fmap_write_sched

Write-side scheduler for the activation SRAM of the Animation-ResNet core. It accepts a stream of 16-bit output activations from the conv/ReLU stage and tracks channel, 2×2 position, column and row with counters. For each activation it issues a registered SRAM write with the matching address, active-low bytemask and aligned write data. It sits between the post-processing pipeline and the activation SRAM, and replaces per-position bytemask lookups with one sequenced controller.

## Interface
- CH_NUM, 24, channels per SRAM word
- ACT_PER_ADDR, 4, activations per channel per word (LU, RU, LD, RD)
- BW_PER_ACT, 16, bits per activation
- ADDR_BW, 10, SRAM address width
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; latches cfg_*; ignored unless IDLE
- cfg_rows  in  6  fmap rows in SRAM words
- cfg_cols  in  6  fmap columns in SRAM words
- cfg_base  in  ADDR_BW  first SRAM address
- in_valid  in  1  activation valid
- in_ready  out  1  activation accepted when in_valid && in_ready
- in_data  in  BW_PER_ACT  activation value
- sram_wen  out  1  active-low write enable
- sram_addr  out  ADDR_BW  write address
- sram_bytemask  out  CH_NUM*ACT_PER_ADDR  active-low per-activation mask
- sram_wdata  out  CH_NUM*ACT_PER_ADDR*BW_PER_ACT  write data
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at end of frame

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start when cfg_rows≠0 and cfg_cols≠0.
  - IDLE→DONE on start when either dimension is 0. No writes are issued.
  - RUN→DRAIN when the final activation is accepted.
  - DRAIN→DONE after the last write is on the bus.
  - DONE→IDLE unconditionally.
- Input order, innermost first: ch 0..CH_NUM-1, then pos 0..3 (LU, RU, LD, RD), then col 0..cfg_cols-1, then row 0..cfg_rows-1.
- Counter wrap:
  - ch wraps to 0 and pos increments.
  - pos wraps to 0 and col increments.
  - col wraps to 0 and row increments.
  - Final activation: row=cfg_rows-1, col=cfg_cols-1, pos=3, ch=CH_NUM-1.
- Address: sram_addr = cfg_base + row*cfg_cols + col. Use a running address register incremented on each col advance; no multiplier. The result wraps modulo 2^ADDR_BW.
- Mask bit index for (ch, pos): k = CH_NUM*ACT_PER_ADDR-1 - (ch*ACT_PER_ADDR + pos).
  - Example: ch0 LU → bit 95; ch1 LU → bit 91; ch23 RD → bit 0.
- Non-merge write: sram_bytemask is all ones except bit k = 0. sram_wdata[k*BW_PER_ACT +: BW_PER_ACT] = in_data; all other bits are 0.
- in_ready is 1 only in RUN.
- start received while busy is ignored.
- rst at any time:
  - Forces IDLE and clears all counters.
  - sram_wen=1, sram_bytemask all ones, sram_addr=0, sram_wdata=0, in_ready=0, busy=0, done=0.
  - Any in-flight write is dropped.

## Timing
- Reset values: sram_wen=1, sram_bytemask all ones, sram_addr=0, sram_wdata=0, in_ready=0, busy=0, done=0.
- start sampled in cycle S → busy=1 and in_ready=1 from cycle S+1.
- Non-merge: activation accepted in cycle N → sram_wen=0 with its addr, mask and data in cycle N+1 only.
- If no handshake in cycle N, cycle N+1 shows sram_wen=1 and the mask returns to all ones.
- Final activation accepted in cycle F:
  - Last write appears in F+1 (DRAIN).
  - done=1 in F+2 (DONE); busy=0 from F+2.
  - IDLE in F+3, where a new start is accepted.
- Zero-dimension start in cycle S → done=1 in S+1; busy stays 0.
- in_valid gaps stall the counters and issue no writes; throughput is 1 activation/cycle.

## Configuration
- WRITE_MERGE_EN defined:
  - A CH_NUM*BW_PER_ACT staging register collects ch 0..CH_NUM-1 for the current pos.
  - On acceptance of ch=CH_NUM-1, one write issues the next cycle. Its mask has bits k(ch,pos)=0 for all CH_NUM channels; all other bits are 1. The data carries all CH_NUM values.
  - in_ready stays 1 in RUN; this costs 1 write per CH_NUM activations.
  - Reset clears the staging register.
- WRITE_MERGE_EN undefined: one write per activation, exactly as in Operation. No staging register is instantiated.

## Test plan
- rst held high for 3 cycles mid-RUN with in_valid=1:
  - Required: sram_wen=1, mask all ones, in_ready=0 and busy=0 the cycle after rst is sampled.
  - Next start restarts at addr cfg_base with ch0 LU.
- cfg_rows=1, cfg_cols=1, cfg_base=0x010, 96 back-to-back activations with in_data = index:
  - 96 writes to 0x010.
  - First write: mask bit 95 = 0, data[95*16 +: 16] = 0.
  - Write 1: bit 91 = 0.
  - Write 24 (ch0, RU): bit 94 = 0.
  - Write 95: bit 0 = 0.
  - done 2 cycles after the last handshake.
- cfg_rows=2, cfg_cols=3, cfg_base=0x3FE, random in_valid gaps:
  - Address sequence 0x3FE, 0x3FF, 0x000, 0x001, 0x002, 0x003; each held for 96 writes.
  - No write in any cycle following a stalled cycle.
- cfg_rows=0, start pulse: done 1 cycle later, no sram_wen=0, busy never high.
- start re-pulsed with different cfg mid-RUN: ignored; the address sequence matches the original cfg.
- WRITE_MERGE_EN, cfg 1×1:
  - Exactly 4 writes.
  - LU write mask: bits 95, 91, …, 3 = 0; all others 1.
  - Each write appears 1 cycle after its ch23 handshake.
